// File: rtl/lc3b_types.sv
// lc3b_types: shared controller state encoding and counter helpers for the cache
package lc3b_types;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        FILL
    } cache_state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// plru_tree: per-set tree pseudo-LRU state with combinational victim and access update
module plru_tree #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SET_BITS-1:0]      index,
    input  logic [$clog2(WAYS)-1:0]  access_way,
    input  logic                     access_en,
    output logic [$clog2(WAYS)-1:0]  victim_way
);
    localparam int WB = $clog2(WAYS);

    // Nodes are heap-numbered from 1 (root); node n has children 2n and 2n+1.
    logic [(1<<SET_BITS)-1:0][WAYS-1:1] r_bits;
    logic [WAYS-1:1]                    w_cur;
    logic [WAYS-1:1]                    w_upd;
    logic [WB-1:0]                      w_vnode;
    logic [WB-1:0]                      w_unode;

    assign w_cur = r_bits[index];

    // Walk from the root following each stored bit (1 = right subtree) to the victim
    always_comb begin
        w_vnode    = WB'(1);
        victim_way = '0;
        for (int l = 0; l < WB; l++) begin
            victim_way = WB'({victim_way, w_cur[w_vnode]});
            w_vnode    = WB'({w_vnode, w_cur[w_vnode]});
        end
    end

    // Point every node on the path to the accessed way at the opposite subtree
    always_comb begin
        w_upd   = w_cur;
        w_unode = WB'(1);
        for (int l = 0; l < WB; l++) begin
            w_upd[w_unode] = ~access_way[WB-1-l];
            w_unode        = WB'({w_unode, access_way[WB-1-l]});
        end
    end

    // Tree bits per set; cleared on reset so every set starts pointing at way 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_bits <= '0;
        else if (access_en) r_bits[index] <= w_upd;
    end

endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way write-back, write-allocate L1 cache with tree-PLRU replacement
module set_assoc_cache
    import lc3b_types::*;
#(
    parameter int WAYS        = 4,
    parameter int SET_BITS    = 3,
    parameter int OFFSET_BITS = 4,
    parameter int ADDR_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            mem_address,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [(1<<OFFSET_BITS)-1:0]  mem_byte_enable,
    input  logic [(8<<OFFSET_BITS)-1:0]  mem_wdata,
    output logic [(8<<OFFSET_BITS)-1:0]  mem_rdata,
    output logic                         mem_resp,
    output logic [ADDR_W-1:0]            pmem_address,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [(8<<OFFSET_BITS)-1:0]  pmem_wdata,
    input  logic [(8<<OFFSET_BITS)-1:0]  pmem_rdata,
    input  logic                         pmem_resp,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
);
    localparam int LINE_W = 8 << OFFSET_BITS;
    localparam int BYTES  = LINE_W / 8;
    localparam int TAG_W  = ADDR_W - SET_BITS - OFFSET_BITS;
    localparam int SETS   = 1 << SET_BITS;
    localparam int WB     = $clog2(WAYS);

    cache_state_t              r_state;
    cache_state_t              w_next_state;
    logic [LINE_W-1:0]         r_data [SETS][WAYS];
    logic [TAG_W-1:0]          r_tag  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0] r_valid;
    logic [SETS-1:0][WAYS-1:0] r_dirty;
    logic [WB-1:0]             r_victim;
    logic                      r_retry;
    logic [CNT_W-1:0]          r_hits;
    logic [CNT_W-1:0]          r_misses;

    logic [TAG_W-1:0]          w_tag;
    logic [SET_BITS-1:0]       w_idx;
    logic                      w_req;
    logic                      w_unused;
    logic [WAYS-1:0]           w_valid;
    logic [WAYS-1:0]           w_dirty;
    logic                      w_hit;
    logic [WB-1:0]             w_hit_way;
    logic                      w_has_inv;
    logic [WB-1:0]             w_inv_way;
    logic [WB-1:0]             w_plru_victim;
    logic [WB-1:0]             w_victim;
    logic [WB-1:0]             w_plru_way;
    logic                      w_plru_en;
    logic                      w_hit_inc;
    logic                      w_miss_inc;
    logic                      w_wb_done;
    logic                      w_fill_done;
    logic                      w_write_hit;
    logic [LINE_W-1:0]         w_merged;

    assign w_tag       = mem_address[ADDR_W-1 -: TAG_W];
    assign w_idx       = mem_address[OFFSET_BITS +: SET_BITS];
    assign w_unused    = ^mem_address[OFFSET_BITS-1:0];
    assign w_req       = mem_read | mem_write;
    assign w_valid     = r_valid[w_idx];
    assign w_dirty     = r_dirty[w_idx];
    assign w_victim    = w_has_inv ? w_inv_way : w_plru_victim;
    assign w_write_hit = mem_resp & mem_write;
    assign mem_rdata   = r_data[w_idx][w_hit_way];
    assign pmem_wdata  = r_data[w_idx][r_victim];
    assign hit_count   = r_hits;
    assign miss_count  = r_misses;

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_valid[w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WB'(w);
            end
        end
    end

    // Lowest-index invalid way; scanning downward leaves the lowest one selected
    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_valid[w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WB'(w);
            end
        end
    end

    // Byte-masked merge of CPU write data into the hitting line
    always_comb begin
        w_merged = mem_rdata;
        for (int b = 0; b < BYTES; b++) begin
            w_merged[8*b +: 8] = mem_byte_enable[b] ? mem_wdata[8*b +: 8] : mem_rdata[8*b +: 8];
        end
    end

    plru_tree #(
        .WAYS     (WAYS),
        .SET_BITS (SET_BITS)
    ) u_plru (
        .clk        (clk),
        .reset_n    (reset_n),
        .index      (w_idx),
        .access_way (w_plru_way),
        .access_en  (w_plru_en),
        .victim_way (w_plru_victim)
    );

    // Controller next state and memory-side outputs
    always_comb begin
        w_next_state = r_state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {w_tag, w_idx, {OFFSET_BITS{1'b0}}};
        w_plru_en    = 1'b0;
        w_plru_way   = w_hit_way;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_wb_done    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            CHECK: begin
                if (w_req && w_hit) begin
                    mem_resp  = 1'b1;
                    w_plru_en = 1'b1;
                    w_hit_inc = ~r_retry;
                end else if (w_req) begin
                    w_miss_inc   = 1'b1;
                    w_next_state = (w_valid[w_victim] && w_dirty[w_victim]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx][r_victim], w_idx, {OFFSET_BITS{1'b0}}};
                w_wb_done    = pmem_resp;
                w_next_state = pmem_resp ? FILL : WRITEBACK;
            end
            FILL: begin
                pmem_read    = 1'b1;
                w_fill_done  = pmem_resp;
                w_plru_en    = pmem_resp;
                w_plru_way   = r_victim;
                w_next_state = pmem_resp ? CHECK : FILL;
            end
            default: w_next_state = CHECK;
        endcase
    end

    // State, latched victim, retry flag (suppresses the post-fill hit count) and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= CHECK;
            r_victim <= '0;
            r_retry  <= 1'b0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_state <= w_next_state;
            r_retry <= w_fill_done | (r_retry & ~mem_resp);
            if (w_miss_inc) r_victim <= w_victim;
            if (w_hit_inc) r_hits <= sat_inc(r_hits);
            if (w_miss_inc) r_misses <= sat_inc(r_misses);
        end
    end

    // Valid and dirty bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_fill_done) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
            end
            if (w_wb_done) r_dirty[w_idx][r_victim] <= 1'b0;
            if (w_write_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
        end
    end

    // Tag and data arrays hold no reset; validity alone decides whether they are used
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[w_idx][r_victim] <= pmem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
        if (w_write_hit) r_data[w_idx][w_hit_way] <= w_merged;
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed scoreboard bench with a 3-cycle backing memory model
module tb_set_assoc_cache;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_byte_enable;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    set_assoc_cache dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] exp_q [$];
    logic [127:0] phys [logic [15:0]];
    logic [127:0] view [logic [15:0]];
    int           wb_n;
    int           rd_n;
    int           lat;
    logic [15:0]  wb_addr;
    logic [15:0]  rd_addr;
    logic [127:0] wb_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [15:0] a);
        return {4{a, ~a}};
    endfunction

    function automatic logic [15:0] la(input logic [15:0] a);
        return {a[15:4], 4'h0};
    endfunction

    function automatic logic [15:0] addr_of(input logic [8:0] tag, input logic [2:0] set);
        return {tag, set, 4'h0};
    endfunction

    function automatic logic [127:0] pget(input logic [15:0] a);
        return phys.exists(a) ? phys[a] : init_line(a);
    endfunction

    function automatic logic [127:0] vget(input logic [15:0] a);
        return view.exists(a) ? view[a] : init_line(a);
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] line, input logic [15:0] be, input logic [127:0] wd);
        logic [127:0] r = line;
        for (int b = 0; b < 16; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One CPU request; the loop also plays the memory side with a 3-cycle response
    task automatic req(input string tag, input logic [15:0] a, input bit wr,
                       input logic [15:0] be, input logic [127:0] wd, input int exp_lat);
        bit done = 1'b0;
        int busy = 0;
        mem_address     = a;
        mem_read        = ~wr;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        wb_n = 0;
        rd_n = 0;
        lat  = -1;
        if (!wr) exp_q.push_back(vget(la(a)));
        #1;
        for (int c = 0; c < 100 && !done; c++) begin
            if (mem_resp) begin
                lat  = c;
                done = 1'b1;
                if (!wr) chk({tag, "_rdata"}, mem_rdata, exp_q.pop_front());
                else view[la(a)] = merge(vget(la(a)), be, wd);
            end else if (pmem_read || pmem_write) begin
                if (busy == 0 && pmem_write) begin
                    wb_n++;
                    wb_addr = pmem_address;
                    wb_data = pmem_wdata;
                end else if (busy == 0) begin
                    rd_n++;
                    rd_addr = pmem_address;
                end
                busy++;
                if (busy == 3) begin
                    if (pmem_write) phys[pmem_address] = pmem_wdata;
                    else pmem_rdata = pget(pmem_address);
                    pmem_resp = 1'b1;
                    busy = 0;
                end
            end
            @(posedge clk);
            #1 pmem_resp = 1'b0;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    endtask

    initial begin
        logic [15:0] ta, tb_, tc, td, te, tp, tq, tr, ts, tf;
        mem_address     = '0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        pmem_rdata      = '0;
        ta = addr_of(9'h010, 3'd3);
        tb_ = addr_of(9'h011, 3'd3);
        tc = addr_of(9'h012, 3'd3);
        td = addr_of(9'h013, 3'd3);
        te = addr_of(9'h014, 3'd3);
        tp = addr_of(9'h020, 3'd5);
        tq = addr_of(9'h021, 3'd5);
        tr = addr_of(9'h022, 3'd5);
        ts = addr_of(9'h023, 3'd5);
        tf = addr_of(9'h024, 3'd5);

        // 1: reset state, then a clean miss on 0x1230
        do_reset();
        chk("rst_hits", 128'(hit_count), 128'(0));
        chk("rst_miss", 128'(miss_count), 128'(0));
        chk("rst_resp", 128'(mem_resp), 128'(0));
        chk("rst_pread", 128'(pmem_read), 128'(0));
        chk("rst_pwrite", 128'(pmem_write), 128'(0));
        req("t1", 16'h1230, 1'b0, 16'h0, 128'h0, 4);
        chk("t1_rd_n", 128'(rd_n), 128'(1));
        chk("t1_rd_addr", 128'(rd_addr), 128'(16'h1230));
        chk("t1_miss", 128'(miss_count), 128'(1));
        chk("t1_hits", 128'(hit_count), 128'(0));

        // 2: same-line hit completes combinationally
        req("t2", 16'h1234, 1'b0, 16'h0, 128'h0, 0);
        chk("t2_rd_n", 128'(rd_n), 128'(0));
        chk("t2_hits", 128'(hit_count), 128'(1));

        // 3: fill set 3, touch A, then E must displace way 2 (C)
        do_reset();
        req("t3_a", ta, 1'b0, 16'h0, 128'h0, 4);
        req("t3_b", tb_, 1'b0, 16'h0, 128'h0, 4);
        req("t3_c", tc, 1'b0, 16'h0, 128'h0, 4);
        req("t3_d", td, 1'b0, 16'h0, 128'h0, 4);
        req("t3_a_hit", ta, 1'b0, 16'h0, 128'h0, 0);
        req("t3_e", te, 1'b0, 16'h0, 128'h0, 4);
        chk("t3_e_wb_n", 128'(wb_n), 128'(0));
        chk("t3_e_rd_addr", 128'(rd_addr), 128'(te));
        req("t3_a_keep", ta, 1'b0, 16'h0, 128'h0, 0);
        req("t3_b_keep", tb_, 1'b0, 16'h0, 128'h0, 0);
        req("t3_d_keep", td, 1'b0, 16'h0, 128'h0, 0);
        req("t3_e_keep", te, 1'b0, 16'h0, 128'h0, 0);
        req("t3_c_gone", tc, 1'b0, 16'h0, 128'h0, 4);
        chk("t3_hits", 128'(hit_count), 128'(5));
        chk("t3_miss", 128'(miss_count), 128'(6));

        // 4: dirty victim R in set 5 is written back before F is fetched
        req("t4_p", tp, 1'b0, 16'h0, 128'h0, 4);
        req("t4_q", tq, 1'b0, 16'h0, 128'h0, 4);
        req("t4_r", tr, 1'b0, 16'h0, 128'h0, 4);
        req("t4_s", ts, 1'b0, 16'h0, 128'h0, 4);
        req("t4_wr", tr, 1'b1, 16'h000C, 128'hBEEF << 16, 0);
        req("t4_s_hit", ts, 1'b0, 16'h0, 128'h0, 0);
        req("t4_p_hit", tp, 1'b0, 16'h0, 128'h0, 0);
        req("t4_f", tf, 1'b0, 16'h0, 128'h0, 7);
        chk("t4_wb_n", 128'(wb_n), 128'(1));
        chk("t4_wb_addr", 128'(wb_addr), 128'(tr));
        chk("t4_wb_bytes", 128'(wb_data[31:16]), 128'(16'hBEEF));
        chk("t4_wb_line", wb_data, vget(tr));
        chk("t4_rd_n", 128'(rd_n), 128'(1));
        chk("t4_rd_addr", 128'(rd_addr), 128'(tf));
        chk("t4_miss", 128'(miss_count), 128'(11));
        chk("t4_hits", 128'(hit_count), 128'(8));
        req("t4_r_back", tr, 1'b0, 16'h0, 128'h0, 4);

        // 5: reset while a fill is outstanding
        do_reset();
        mem_address = 16'h4440;
        mem_read    = 1'b1;
        #1;
        for (int c = 0; c < 10 && !pmem_read; c++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_pread_up", 128'(pmem_read), 128'(1));
        reset_n  = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("t5_pread_async", 128'(pmem_read), 128'(0));
        chk("t5_resp_async", 128'(mem_resp), 128'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_hits0", 128'(hit_count), 128'(0));
        chk("t5_miss0", 128'(miss_count), 128'(0));
        req("t5_reread", 16'h4440, 1'b0, 16'h0, 128'h0, 4);
        chk("t5_rd_n", 128'(rd_n), 128'(1));
        chk("t5_miss", 128'(miss_count), 128'(1));
        chk("t5_hits", 128'(hit_count), 128'(0));

        // 6: hold a hitting read until the hit counter saturates
        mem_address = 16'h4440;
        mem_read    = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("t6_fffe", 128'(hit_count), 128'(16'hFFFE));
        @(posedge clk);
        #1;
        chk("t6_ffff", 128'(hit_count), 128'(16'hFFFF));
        chk("t6_resp", 128'(mem_resp), 128'(1));
        @(posedge clk);
        #1;
        chk("t6_sat", 128'(hit_count), 128'(16'hFFFF));
        chk("t6_miss", 128'(miss_count), 128'(1));
        mem_read = 1'b0;

        chk("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
